// File: rtl/s32x_fb_arbiter.sv
// 32X VDP framebuffer port scheduler: one RAM slot per dot shared by display
// fetch, the auto-fill sequencer and SH2/68K bus accesses.
module s32x_fb_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int FLW = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           DOT_CE,
  input  logic           DISP_REQ,
  input  logic [AW-1:0]  DISP_A,
  output logic [DW-1:0]  DISP_Q,
  output logic           DISP_VALID,
  input  logic           FILL_START,
  input  logic [AW-1:0]  FILL_A,
  input  logic [DW-1:0]  FILL_D,
  input  logic [FLW-1:0] FILL_LEN,
  output logic           FILL_BUSY,
  output logic [AW-1:0]  FILL_AQ,
  input  logic           CPU_REQ,
  input  logic [1:0]     CPU_WE,
  input  logic [AW-1:0]  CPU_A,
  input  logic [DW-1:0]  CPU_D,
  output logic [DW-1:0]  CPU_Q,
  output logic           CPU_ACK,
  output logic [AW-1:0]  FB_A,
  output logic [DW-1:0]  FB_DO,
  output logic [1:0]     FB_WE,
  input  logic [DW-1:0]  FB_DI
);

  typedef enum logic [1:0] {
    CPU_IDLE  = 2'd0,
    CPU_WAIT  = 2'd1,
    CPU_RDLAT = 2'd2,
    CPU_ACKS  = 2'd3
  } cpu_st_t;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_st_t;

  localparam logic [2:0] STARVE_MAX = 3'd4;

  cpu_st_t        r_cpu_st;
  fill_st_t       r_fill_st;
  logic [AW-1:0]  r_fill_addr;
  logic [DW-1:0]  r_fill_data;
  logic [FLW-1:0] r_fill_cnt;
  logic [2:0]     r_starve;
  logic [AW-1:0]  r_fb_a;
  logic [DW-1:0]  r_fb_do;
  logic           r_disp_p1;
  logic           r_disp_valid;
  logic [DW-1:0]  r_disp_q;
  logic           r_cpu_ack;
  logic [DW-1:0]  r_cpu_q;

  logic           w_disp_g;
  logic           w_cpu_g;
  logic           w_fill_g;
  logic [AW-1:0]  w_fb_a;
  logic [DW-1:0]  w_fb_do;
  logic [1:0]     w_fb_we;
  logic [AW-1:0]  w_fill_next;

  // Line-wrapping fill address: only the low byte advances.
  assign w_fill_next = {r_fill_addr[AW-1:8], r_fill_addr[7:0] + 8'd1};

  // Slot arbitration; reset masks every grant so no write escapes mid-reset.
  always_comb begin
    w_disp_g = 1'b0;
    w_cpu_g  = 1'b0;
    w_fill_g = 1'b0;
    if (!RST && DOT_CE) begin
      if (DISP_REQ) begin
        w_disp_g = 1'b1;
      end else if ((r_cpu_st == CPU_WAIT) &&
                   ((r_fill_st == FILL_IDLE) || (r_starve == STARVE_MAX))) begin
        w_cpu_g = 1'b1;
      end else if (r_fill_st == FILL_RUN) begin
        w_fill_g = 1'b1;
      end else begin
        w_fill_g = 1'b0;
      end
    end else begin
      w_disp_g = 1'b0;
    end
  end

  // RAM port mux; address and data hold between slots.
  always_comb begin
    w_fb_a  = r_fb_a;
    w_fb_do = r_fb_do;
    w_fb_we = 2'b00;
    if (w_disp_g) begin
      w_fb_a  = DISP_A;
      w_fb_do = {DW{1'b0}};
    end else if (w_cpu_g) begin
      w_fb_a  = CPU_A;
      w_fb_do = CPU_D;
      w_fb_we = CPU_WE;
    end else if (w_fill_g) begin
      w_fb_a  = r_fill_addr;
      w_fb_do = r_fill_data;
      w_fb_we = 2'b11;
    end else begin
      w_fb_we = 2'b00;
    end
  end

  // Port hold registers, bus starvation counter and display read pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fb_a       <= {AW{1'b0}};
      r_fb_do      <= {DW{1'b0}};
      r_starve     <= 3'd0;
      r_disp_p1    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_q     <= {DW{1'b0}};
    end else begin
      r_fb_a       <= w_fb_a;
      r_fb_do      <= w_fb_do;
      r_disp_p1    <= w_disp_g;
      r_disp_valid <= r_disp_p1;
      if (r_disp_p1) begin
        r_disp_q <= FB_DI;
      end
      if (w_cpu_g || (r_cpu_st != CPU_WAIT)) begin
        r_starve <= 3'd0;
      end else if (w_fill_g && (r_starve != STARVE_MAX)) begin
        r_starve <= r_starve + 3'd1;
      end
    end
  end

  // Auto-fill sequencer: FILL_LEN+1 beats, one per fill grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fill_st   <= FILL_IDLE;
      r_fill_addr <= {AW{1'b0}};
      r_fill_data <= {DW{1'b0}};
      r_fill_cnt  <= {FLW{1'b0}};
    end else begin
      case (r_fill_st)
        FILL_IDLE: begin
          if (FILL_START) begin
            r_fill_st   <= FILL_RUN;
            r_fill_addr <= FILL_A;
            r_fill_data <= FILL_D;
            r_fill_cnt  <= FILL_LEN;
          end
        end
        FILL_RUN: begin
          if (w_fill_g) begin
            r_fill_addr <= w_fill_next;
            r_fill_cnt  <= r_fill_cnt - {{(FLW-1){1'b0}}, 1'b1};
            if (r_fill_cnt == {FLW{1'b0}}) begin
              r_fill_st <= FILL_IDLE;
            end
          end
        end
        default: r_fill_st <= FILL_IDLE;
      endcase
    end
  end

  // Bus handshake: reads need one extra CLK for the RAM data to arrive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cpu_st  <= CPU_IDLE;
      r_cpu_ack <= 1'b0;
      r_cpu_q   <= {DW{1'b0}};
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_cpu_st)
        CPU_IDLE: begin
          if (CPU_REQ) begin
            r_cpu_st <= CPU_WAIT;
          end
        end
        CPU_WAIT: begin
          if (w_cpu_g) begin
            if (CPU_WE != 2'b00) begin
              r_cpu_st  <= CPU_ACKS;
              r_cpu_ack <= 1'b1;
            end else begin
              r_cpu_st <= CPU_RDLAT;
            end
          end
        end
        CPU_RDLAT: begin
          r_cpu_q   <= FB_DI;
          r_cpu_ack <= 1'b1;
          r_cpu_st  <= CPU_ACKS;
        end
        CPU_ACKS: r_cpu_st <= CPU_IDLE;
        default:  r_cpu_st <= CPU_IDLE;
      endcase
    end
  end

  assign FB_A       = w_fb_a;
  assign FB_DO      = w_fb_do;
  assign FB_WE      = w_fb_we;
  assign DISP_Q     = r_disp_q;
  assign DISP_VALID = r_disp_valid;
  assign FILL_BUSY  = (r_fill_st == FILL_RUN);
  assign FILL_AQ    = r_fill_addr;
  assign CPU_Q      = r_cpu_q;
  assign CPU_ACK    = r_cpu_ack;

endmodule

// File: doc/s32x_fb_arbiter.md
Name: s32x_fb_arbiter

Overview:
Single-port framebuffer access scheduler for the 32X VDP draw/display buffer.
- Shares one synchronous FB RAM port among three requesters: display line fetch, auto-fill engine, and SH2/68K bus access.
- One access slot per dot (DOT_CE); fixed priority with an anti-starvation rule for the bus.
- Contains the auto-fill sequencer (address/length counters), so the register block only issues a start command.

Parameters:
AW, 16, FB word address width
DW, 16, FB data width
FLW, 8, fill length / fill counter width

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
DOT_CE  in  1  slot strobe; one arbitration slot per CLK where DOT_CE=1
DISP_REQ  in  1  display needs the slot (sampled only when DOT_CE=1)
DISP_A  in  AW  display fetch word address
DISP_Q  out  DW  display read data
DISP_VALID  out  1  1-CLK pulse: DISP_Q updated
FILL_START  in  1  1-CLK start pulse for auto-fill
FILL_A  in  AW  fill start address
FILL_D  in  DW  fill data word
FILL_LEN  in  FLW  fill length minus one
FILL_BUSY  out  1  fill in progress
FILL_AQ  out  AW  current fill address, for register readback
CPU_REQ  in  1  bus request; level, held until CPU_ACK
CPU_WE  in  2  byte write enables {upper,lower}; 00 = read
CPU_A  in  AW  bus word address
CPU_D  in  DW  bus write data
CPU_Q  out  DW  bus read data
CPU_ACK  out  1  1-CLK completion pulse
FB_A  out  AW  RAM address
FB_DO  out  DW  RAM write data
FB_WE  out  2  RAM byte write enables
FB_DI  in  DW  RAM read data, 1-CLK latency

Behaviour:
- Reset: all outputs 0; fill counters, starvation counter and CPU state cleared.
  - RST during a fill aborts it: FILL_BUSY=0, remaining words not written.
  - RST during a pending bus access drops it with no ACK.
- Grant happens only in a CLK with DOT_CE=1. Priority: DISP > FILL > CPU.
  - Exception: if CPU_REQ has been pending through 4 consecutive FILL grants, the next non-display slot goes to the CPU. The counter is then cleared. It also clears whenever a CPU grant occurs.
- Granted CLK: FB_A, FB_DO and FB_WE come from the winner. FB_WE is nonzero only in that CLK. Non-slot CLKs: FB_WE=00 and FB_A holds its value.
- DISP grant: read only. The CLK after the grant, DISP_Q<=FB_DI and DISP_VALID=1.
- FILL sequencer, states IDLE/FILL:
  - FILL_START in IDLE latches the address counter<=FILL_A, data<=FILL_D, count<=FILL_LEN, and sets FILL_BUSY=1 in the next CLK.
  - FILL_START while busy is ignored.
  - Each FILL grant writes FB_WE=11 and increments address[7:0] by 1. address[15:8] is held, so the address wraps within a 256-word line (xxFF -> xx00).
  - Count decrements per grant. The grant made with count=0 is the last write; FILL_BUSY=0 the CLK after it.
  - Total writes = FILL_LEN+1 (0 -> 1 word, 255 -> 256 words).
  - FILL_AQ always shows the next address to write.
- CPU handshake, states IDLE/WAIT/RDLAT/ACK:
  - CPU_REQ in IDLE -> WAIT. CPU_A, CPU_D and CPU_WE are sampled at the grant.
  - Write grant at CLK N: CPU_ACK=1 at N+1.
  - Read grant at CLK N: RAM data at N+1, CPU_Q<=FB_DI, CPU_ACK=1 at N+2.
  - CPU_Q holds until the next read.
  - After ACK the requester must drop CPU_REQ. A request still high in the ACK CLK is not re-granted until after ACK; it is then treated as a new request.
  - CPU_WE with one byte set writes only that byte lane.
- Simultaneous events:
  - FILL_START and a grant in the same CLK: the fill competes from the next slot.
  - DISP_REQ=1 on every slot starves both FILL and CPU, by design; display windows are bounded.
  - CPU and FILL never both pending on the RAM in one slot.
- Maximum outstanding transactions: 1 CPU access and 1 fill beat per slot.

Test Plan:
- Reset: RST=1 for 2 CLK with CPU_REQ=1 and FILL_START pulsed -> all outputs 0, no FB_WE, no ACK.
- Fill: FILL_A=0x12FE, FILL_LEN=3, FILL_D=0xA5A5, DOT_CE every 2 CLK, no other requesters -> writes at 0x12FE, 0x12FF, 0x1200, 0x1201 with FB_WE=11; FILL_BUSY falls after the 4th write; FILL_AQ=0x1202.
- CPU read: DOT_CE=1 every CLK, CPU_A=0x0040, RAM[0x40]=0xBEEF -> grant at N, CPU_ACK and CPU_Q=0xBEEF at N+2. CPU write CPU_WE=01, CPU_D=0x1234 to 0x0041 -> FB_WE=01 at grant, ACK at N+1.
- Priority: DISP_REQ, active fill and CPU_REQ all present -> display wins; while DISP_REQ=0, fill gets 4 slots, CPU gets the 5th, then fill resumes.
- Display path: DISP_REQ=1, DISP_A=0x0007, RAM=0x00C3 -> DISP_VALID pulse with DISP_Q=0x00C3 one CLK after the slot.
- Boundaries: FILL_LEN=0 -> exactly 1 write. FILL_LEN=255 -> 256 writes, address wraps to the start. FILL_START while busy -> no restart. RST mid-fill -> writes stop at once.
